// File: rtl/sha_core_arbiter.sv
// Round-robin front end that shares one sha256_block core between NUM_REQ requesters;
// a watchdog turns a core that never reports done into an error response.
module sha_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*512-1:0]   req_block,
    input  logic [NUM_REQ*256-1:0]   req_hinit,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     core_start,
    output logic [511:0]             core_block,
    output logic [255:0]             core_h_init,
    input  logic                     core_done,
    input  logic [255:0]             core_hash,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [255:0]             rsp_hash,
    output logic                     rsp_err,
    output logic                     busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t               r_state;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        r_rr_ptr;
    logic [15:0]          r_wd_cnt;
    logic                 r_wait_first;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic                 r_core_start;
    logic [511:0]         r_core_block;
    logic [255:0]         r_core_h_init;
    logic [255:0]         r_rsp_hash;
    logic                 r_rsp_err;
    logic                 r_busy;

    logic [511:0]         w_blk   [NUM_REQ];
    logic [255:0]         w_hinit [NUM_REQ];
    logic [IW-1:0]        w_win;
    logic [IW-1:0]        w_pos;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [NUM_REQ-1:0]   w_idx_oh;
    logic [15:0]          w_wd_next;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_blk[gi]   = req_block[gi*512 +: 512];
        assign w_hinit[gi] = req_hinit[gi*256 +: 256];
    end

    // Round-robin pick: scanning downward leaves the smallest offset from r_rr_ptr as winner.
    always_comb begin
        w_win = '0;
        w_pos = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req[w_pos]) begin
                w_win = w_pos;
            end else begin
                w_win = w_win;
            end
        end
    end

    assign w_win_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
    assign w_idx_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx;
    assign w_wd_next = (r_wd_cnt == 16'hFFFF) ? r_wd_cnt : r_wd_cnt + 16'd1;

    // Arbiter state machine; every output is a register written here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_rr_ptr      <= '0;
            r_wd_cnt      <= 16'd0;
            r_wait_first  <= 1'b0;
            r_gnt         <= '0;
            r_rsp_valid   <= '0;
            r_core_start  <= 1'b0;
            r_core_block  <= '0;
            r_core_h_init <= '0;
            r_rsp_hash    <= '0;
            r_rsp_err     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_idx   <= w_win;
                        r_gnt   <= w_win_oh;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_gnt         <= '0;
                    r_core_block  <= w_blk[r_idx];
                    r_core_h_init <= w_hinit[r_idx];
                    r_core_start  <= 1'b1;
                    r_state       <= S_START;
                end
                S_START: begin
                    r_core_start <= 1'b0;
                    r_wd_cnt     <= 16'd0;
                    r_wait_first <= 1'b1;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    // The first WAIT cycle may still see done from the previous job.
                    r_wait_first <= 1'b0;
                    r_wd_cnt     <= w_wd_next;
                    if (!r_wait_first && core_done) begin
                        r_rsp_hash  <= core_hash;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= w_idx_oh;
                        r_state     <= S_RESP;
                    end else if (w_wd_next >= 16'(TIMEOUT)) begin
                        r_rsp_hash  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= w_idx_oh;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= '0;
                    r_rr_ptr    <= (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + IW'(1);
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_gnt        <= '0;
                    r_rsp_valid  <= '0;
                    r_core_start <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign core_start  = r_core_start;
    assign core_block  = r_core_block;
    assign core_h_init = r_core_h_init;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_hash    = r_rsp_hash;
    assign rsp_err     = r_rsp_err;
    assign busy        = r_busy;

endmodule
